// File: rtl/analysis_seq.sv
// Peak-bin finder: captures a 16-bin complex frame and scans it one bin per cycle for the largest re^2+im^2.
// Latency: capture edge E0 -> done/freq valid for the cycle after E16.
// Backpressure: a frame strobe is ignored while busy and reported by a one-cycle overrun pulse.
//
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   fft_valid           frame strobe, fft_d0..fft_d15 sampled on that edge
//   fft_d0..fft_d15     bin k = {re[31:16], im[15:0]}, two's complement
//   busy                high while the captured frame is being scanned
//   done                one-cycle pulse, freq (and amp_max) valid
//   freq                index of the peak-magnitude bin, held until the next result
//   overrun             one-cycle pulse, a strobe arrived while busy and was dropped
//   amp_max             peak magnitude, present only when ANALYSIS_SEQ_AMP_OUT_EN is defined
//
// Build option: define ANALYSIS_SEQ_AMP_OUT_EN to add the amp_max output and its register.

module analysis_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        busy,
  output logic        done,
  output logic [3:0]  freq,
  output logic        overrun
`ifdef ANALYSIS_SEQ_AMP_OUT_EN
  ,
  output logic [31:0] amp_max
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] bin_q [16];
  logic [3:0]  cnt_q;
  logic [31:0] run_max_q;
  logic [3:0]  run_idx_q;
  logic        busy_q;
  logic        done_q;
  logic        overrun_q;
  logic [3:0]  freq_q;
`ifdef ANALYSIS_SEQ_AMP_OUT_EN
  logic [31:0] amp_max_q;
`endif

  // Flatten the bin ports so capture can be a simple loop.
  logic [31:0] fft_in [16];
  assign fft_in[0]  = fft_d0;
  assign fft_in[1]  = fft_d1;
  assign fft_in[2]  = fft_d2;
  assign fft_in[3]  = fft_d3;
  assign fft_in[4]  = fft_d4;
  assign fft_in[5]  = fft_d5;
  assign fft_in[6]  = fft_d6;
  assign fft_in[7]  = fft_d7;
  assign fft_in[8]  = fft_d8;
  assign fft_in[9]  = fft_d9;
  assign fft_in[10] = fft_d10;
  assign fft_in[11] = fft_d11;
  assign fft_in[12] = fft_d12;
  assign fft_in[13] = fft_d13;
  assign fft_in[14] = fft_d14;
  assign fft_in[15] = fft_d15;

  // The one squarer pair works on whichever captured bin the counter selects.
  logic [31:0]        cur_bin;
  logic signed [31:0] cur_re;
  logic signed [31:0] cur_im;
  logic signed [31:0] sq_re;
  logic signed [31:0] sq_im;
  logic [31:0]        amp;

  assign cur_bin = bin_q[cnt_q];
  assign cur_re  = {{16{cur_bin[31]}}, cur_bin[31:16]};
  assign cur_im  = {{16{cur_bin[15]}}, cur_bin[15:0]};
  assign sq_re   = cur_re * cur_re;
  assign sq_im   = cur_im * cur_im;
  // Each square is at most 2^30, so the unsigned sum peaks at exactly 2^31 and never wraps.
  assign amp     = $unsigned(sq_re) + $unsigned(sq_im);

  // Strictly-greater replacement keeps the lowest index on ties.
  logic        amp_gt;
  logic [31:0] run_max_d;
  logic [3:0]  run_idx_d;

  assign amp_gt    = (amp > run_max_q);
  assign run_max_d = amp_gt ? amp : run_max_q;
  assign run_idx_d = amp_gt ? cnt_q : run_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      run_max_q <= 32'd0;
      run_idx_q <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      freq_q    <= 4'd0;
`ifdef ANALYSIS_SEQ_AMP_OUT_EN
      amp_max_q <= 32'd0;
`endif
      for (int i = 0; i < 16; i++) begin
        bin_q[i] <= 32'd0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        // DONE lasts one cycle and accepts a new frame exactly like IDLE,
        // which gives back-to-back frames with no idle gap.
        ST_IDLE, ST_DONE: begin
          if (fft_valid) begin
            for (int i = 0; i < 16; i++) begin
              bin_q[i] <= fft_in[i];
            end
            cnt_q     <= 4'd0;
            run_max_q <= 32'd0;
            run_idx_q <= 4'd0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          // A strobe here is dropped; the in-flight frame is untouched.
          overrun_q <= fft_valid;
          run_max_q <= run_max_d;
          run_idx_q <= run_idx_d;
          cnt_q     <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Result is taken from the next-state values so bin 15 counts.
            freq_q  <= run_idx_d;
`ifdef ANALYSIS_SEQ_AMP_OUT_EN
            amp_max_q <= run_max_d;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign freq    = freq_q;
  assign overrun = overrun_q;
`ifdef ANALYSIS_SEQ_AMP_OUT_EN
  assign amp_max = amp_max_q;
`endif

endmodule

// File: doc/analysis_seq.md
ANALYSIS_SEQ -- requirements
Module: analysis_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port: fft_valid  input  1  frame strobe; fft_d0..fft_d15 valid this cycle.
REQ-004 SHALL have ports: fft_d0..fft_d15  input  32 each  bin k = {re[31:16], im[15:0]}, two's complement.
REQ-005 SHALL have port: busy  output  1  high while a frame is being scanned.
REQ-006 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-007 SHALL have port: freq  output  4  index of peak-magnitude bin.
REQ-008 SHALL have port: overrun  output  1  one-cycle pulse, frame dropped.

Function
REQ-009 SHALL use exactly one squarer pair, time-multiplexed one bin per cycle; amp = re*re + im*im, signed products, 32-bit unsigned sum, no overflow (max 2^31).
REQ-010 SHALL implement states IDLE, SCAN, DONE.
REQ-011 SHALL, on an edge with fft_valid=1 in IDLE or DONE, register all 16 bins, clear bin counter, running max and index to 0, and enter SCAN.
REQ-012 SHALL, in SCAN, process bin k on the k-th edge after capture (k=0..15), replacing running max/index only when amp is strictly greater, so equal peaks resolve to the lowest index.
REQ-013 SHALL enter DONE on the edge processing bin 15, and drive done=1 for exactly the following cycle: capture edge E0, done high between E16 and E17 (16-cycle latency).
REQ-014 SHALL drive freq from a register updated only when entering DONE, held until the next DONE.
REQ-015 SHALL leave DONE after one cycle: to SCAN if fft_valid=1 on that edge (back-to-back accepted), else IDLE.
REQ-016 SHALL drive busy=1 exactly while in SCAN.
REQ-017 SHALL ignore fft_valid in SCAN, keep the in-flight frame unchanged, and pulse overrun=1 for the cycle after each such edge.
REQ-018 SHALL treat an all-zero frame as peak 0, freq=0.
REQ-019 SHALL not depend on fft_d* outside the capture edge.

Reset
REQ-020 SHALL, on an edge with rst=1, enter IDLE, clear counter, captured bins, running max/index, freq, done, busy, overrun to 0; rst has priority over fft_valid.
REQ-021 SHALL abandon any frame in SCAN on reset without a done pulse; first frame after reset is accepted on the edge following rst deassertion.

Configuration
REQ-022 SHALL, with macro ANALYSIS_SEQ_AMP_OUT_EN defined, add port amp_max  output  32  peak magnitude, loaded with freq, reset 0.
REQ-023 SHALL, without ANALYSIS_SEQ_AMP_OUT_EN, omit amp_max and its register; all other behaviour identical.

Verification
REQ-024 Single peak: bin 5 = {re=100, im=0}, others 0 -> done pulses 16 cycles after capture, freq=5, amp_max=10000 when enabled.
REQ-025 Tie plus sign: bin 3 = {-300,400}, bin 9 = {500,0}, bin 12 = {0,-500} -> freq=3, amp_max=250000.
REQ-026 Extremes: bin 15 = {-32768,-32768}, others {32767,0} -> freq=15, amp_max=0x80000000.
REQ-027 Overrun: fft_valid at E0 and E5 -> overrun pulse once after E5, result from E0 frame, single done.
REQ-028 Back-to-back: second fft_valid on the edge leaving DONE -> busy reasserts with no IDLE cycle, second done 16 cycles later, freq updated.
REQ-029 Reset mid-scan: rst at E8 -> no done, all outputs 0, next frame processed normally with correct freq.
